sc_collision_scanner: RTL and testbench

- Sequences one shared obstacle/car overlap comparator across the playfield rows occupied by the player car, once per frame tick.
- Reads obstacle rows from the playfield matrix through an address/data port.
- Drives both comparator input buses and samples its active-low overlap output.
- Reports a latched collision flag, the first colliding row, and a one-cycle scan-done pulse to the game FSM.

---
 rtl/sc_collision_scanner.sv | 112 +++++++++++
 tb/tb_sc_collision_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_collision_scanner.sv
// Collision scanner: runs one shared overlap comparator over the car's rows each frame tick.
// Ports: clock/reset, start/clear, car row+mask, playfield read port, comparator buses, status.
module sc_collision_scanner #(
  parameter int DATAWIDTH     = 8,
  parameter int ROWS          = 16,
  parameter int ROWADDR_WIDTH = 4,
  parameter int CAR_HEIGHT    = 4
) (
  input  logic                     SC_CollisionScan_CLOCK_50,
  input  logic                     SC_CollisionScan_RESET_InLow,
  input  logic                     start_InHigh,
  input  logic                     clear_InHigh,
  input  logic [ROWADDR_WIDTH-1:0] car_row_In,
  input  logic [DATAWIDTH-1:0]     car_mask_In,
  output logic [ROWADDR_WIDTH-1:0] row_addr_Out,
  input  logic [DATAWIDTH-1:0]     row_data_In,
  output logic [DATAWIDTH-1:0]     cmp_bus1_Out,
  output logic [DATAWIDTH-1:0]     cmp_bus2_Out,
  input  logic                     cmp_outlow_In,
  output logic                     busy_Out,
  output logic                     done_Out,
  output logic                     collision_Out,
  output logic [ROWADDR_WIDTH-1:0] hit_row_Out
);

  localparam int AW = ROWADDR_WIDTH;
  localparam int DW = DATAWIDTH;
  localparam int CW = ROWADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(CAR_HEIGHT - 1);
  localparam logic [AW-1:0] TOP  = AW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CMP,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] row_addr, row_addr_nx;
  logic [AW-1:0] hit_row, hit_row_nx;
  logic [DW-1:0] car_mask, car_mask_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          collision, collision_nx;

  always_ff @(posedge SC_CollisionScan_CLOCK_50) begin
    if (!SC_CollisionScan_RESET_InLow) begin
      state     <= IDLE;
      row_addr  <= '0;
      hit_row   <= '0;
      car_mask  <= '0;
      cnt       <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_nx;
      row_addr  <= row_addr_nx;
      hit_row   <= hit_row_nx;
      car_mask  <= car_mask_nx;
      cnt       <= cnt_nx;
      collision <= collision_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    row_addr_nx  = row_addr;
    hit_row_nx   = hit_row;
    car_mask_nx  = car_mask;
    cnt_nx       = cnt;
    collision_nx = collision;
    case (state)
      IDLE: begin
        if (start_InHigh) begin
          // row_addr doubles as the car_row snapshot
          row_addr_nx  = car_row_In;
          car_mask_nx  = car_mask_In;
          cnt_nx       = '0;
          collision_nx = 1'b0;
          state_nx     = ADDR;
        end else if (clear_InHigh) begin
          collision_nx = 1'b0;
        end
      end
      ADDR: state_nx = CMP;
      CMP: begin
        if (!cmp_outlow_In) begin
          collision_nx = 1'b1;
          hit_row_nx   = row_addr;
          state_nx     = DONE;
        end else if (cnt == LAST) begin
          state_nx = DONE;
        end else begin
          cnt_nx      = cnt + 1'b1;
          row_addr_nx = (row_addr == TOP) ? '0 : row_addr + 1'b1;
          state_nx    = ADDR;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Obstacle bus is zero outside CMP so the comparator idles high.
  assign cmp_bus1_Out  = (state == CMP) ? row_data_In : '0;
  assign cmp_bus2_Out  = car_mask;
  assign row_addr_Out  = row_addr;
  assign busy_Out      = (state != IDLE);
  assign done_Out      = (state == DONE);
  assign collision_Out = collision;
  assign hit_row_Out   = hit_row;

endmodule

// File: tb/tb_sc_collision_scanner.sv
// Bench for sc_collision_scanner: playfield memory and comparator models,
// vector table, hand sequences and randomized scans against a reference model.
module tb_sc_collision_scanner;

  localparam int ROWS = 16;
  localparam int CH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] car_row = '0;
  logic [7:0] car_mask = '0;
  logic [3:0] row_addr;
  logic [7:0] row_data;
  logic [7:0] bus1, bus2;
  logic       outlow;
  logic       busy, done, collision;
  logic [3:0] hit_row;

  logic [7:0] mem [ROWS];

  int checks = 0;
  int errors = 0;
  logic [3:0] model_hit;

  always #5 clk = ~clk;

  always @(posedge clk) row_data <= mem[row_addr];

  assign outlow = ~|(bus1 & bus2);

  sc_collision_scanner dut (
    .SC_CollisionScan_CLOCK_50   (clk),
    .SC_CollisionScan_RESET_InLow(rst_n),
    .start_InHigh                (start),
    .clear_InHigh                (clear),
    .car_row_In                  (car_row),
    .car_mask_In                 (car_mask),
    .row_addr_Out                (row_addr),
    .row_data_In                 (row_data),
    .cmp_bus1_Out                (bus1),
    .cmp_bus2_Out                (bus2),
    .cmp_outlow_In               (outlow),
    .busy_Out                    (busy),
    .done_Out                    (done),
    .collision_Out               (collision),
    .hit_row_Out                 (hit_row)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < ROWS; i++) mem[i] = 8'h00;
  endtask

  // Runs one scan from IDLE and checks timing, addresses and result.
  task automatic run_scan(input logic [3:0] car, input logic [7:0] mask,
                          input bit clr, input bit noise,
                          input logic ecol, input logic [3:0] ehit,
                          input int elat);
    int bn, dn, didx, bad;
    logic [7:0] m0;
    logic [3:0] ea;
    bn = 0; dn = 0; didx = -1; bad = 0; m0 = '0;
    @(negedge clk);
    car_row = car; car_mask = mask; start = 1'b1; clear = clr;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      if (bn == 0) m0 = bus2;
      if (done) begin
        dn++;
        didx = bn;
      end else begin
        ea = 4'((int'(car) + bn / 2) % ROWS);
        if (row_addr !== ea) bad++;
      end
      bn++;
      if (noise) begin
        start = 1'($urandom);
        clear = 1'($urandom);
        car_row = 4'($urandom);
        car_mask = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; clear = 1'b0;
    chk("busy_cycles", bn, elat);
    chk("done_count", dn, 1);
    chk("done_last", didx, elat - 1);
    chk("addr_seq_bad", bad, 0);
    chk("bus2_mask", m0, mask);
    chk("collision", collision, ecol);
    chk("hit_row", hit_row, ehit);
  endtask

  // Reference: first car row whose obstacle overlaps the mask.
  task automatic model(input logic [3:0] car, input logic [7:0] mask,
                       output logic col, output logic [3:0] hit,
                       output int lat);
    int r;
    col = 1'b0; hit = model_hit; lat = 2 * CH + 1;
    for (int k = 0; k < CH; k++) begin
      r = (int'(car) + k) % ROWS;
      if ((mem[r] & mask) != 0) begin
        col = 1'b1; hit = 4'(r); lat = 2 * k + 3;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] car;
    logic [7:0] mask;
    logic [3:0] orow;
    logic [7:0] oval;
    bit         noise;
    logic       col;
    logic [3:0] hit;
    int         lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic ecol;
    logic [3:0] ehit;
    int elat;
    bit dseen;

    tbl[0] = '{4'd5,  8'h18, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  9};
    tbl[1] = '{4'd5,  8'h18, 4'd7,  8'h10, 1'b1, 1'b1, 4'd7,  7};
    tbl[2] = '{4'd14, 8'h18, 4'd1,  8'h08, 1'b0, 1'b1, 4'd1,  9};
    tbl[3] = '{4'd3,  8'h18, 4'd3,  8'h81, 1'b1, 1'b0, 4'd1,  9};
    tbl[4] = '{4'd0,  8'h00, 4'd0,  8'hff, 1'b0, 1'b0, 4'd1,  9};
    tbl[5] = '{4'd12, 8'h01, 4'd12, 8'h01, 1'b1, 1'b1, 4'd12, 3};

    clear_mem();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_col", collision, 0);
    chk("rst_hit", hit_row, 0);
    chk("rst_addr", row_addr, 0);
    chk("rst_bus1", bus1, 0);
    chk("rst_bus2", bus2, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      clear_mem();
      mem[tbl[i].orow] = tbl[i].oval;
      run_scan(tbl[i].car, tbl[i].mask, 1'b0, tbl[i].noise,
               tbl[i].col, tbl[i].hit, tbl[i].lat);
    end

    // clear in IDLE drops the flag but keeps hit_row
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("idle_clear_col", collision, 0);
    chk("idle_clear_hit", hit_row, 12);

    // hit, then start+clear together on a clean field
    clear_mem();
    mem[7] = 8'h10;
    run_scan(4'd5, 8'h18, 1'b0, 1'b0, 1'b1, 4'd7, 7);
    clear_mem();
    run_scan(4'd0, 8'h18, 1'b1, 1'b0, 1'b0, 4'd7, 9);

    // reset during the third CMP of a hitting scan
    clear_mem();
    mem[7] = 8'h10;
    dseen = 1'b0;
    @(negedge clk);
    car_row = 4'd5; car_mask = 8'h18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      dseen |= done;
      @(negedge clk);
    end
    chk("mid_row_addr", row_addr, 7);
    chk("mid_bus1", bus1, 8'h10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_col", collision, 0);
    chk("mid_rst_hit", hit_row, 0);
    chk("mid_rst_addr", row_addr, 0);
    repeat (12) begin
      dseen |= done;
      @(negedge clk);
    end
    chk("mid_rst_no_done", dseen, 0);
    model_hit = 4'd0;

    for (int n = 0; n < 40; n++) begin
      logic [3:0] c;
      logic [7:0] m;
      for (int i = 0; i < ROWS; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      c = 4'($urandom);
      m = 8'($urandom);
      model(c, m, ecol, ehit, elat);
      run_scan(c, m, 1'($urandom), 1'($urandom), ecol, ehit, elat);
      model_hit = ehit;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
